// File: rtl/wb_rob_writer.sv
// wb_rob_writer
// Writeback-side consumer of the M/WB pipeline register. Each valid M/WB bundle
// is queued in a DEPTH-entry FIFO and presented to the ROB result-write port
// through a valid/ready handshake. The FIFO absorbs cycles in which the ROB
// port is busy, and stall_out holds the M stage while the FIFO is full.
//
// Optional feature (macro WB_BYPASS_EN):
//   If defined and the FIFO is empty, a valid bundle that the ROB can accept
//   in the same cycle (rob_wr_ready=1, flush=0) goes straight to rob_wr_*
//   combinationally and is not stored. If the macro is not defined, every
//   bundle goes through the FIFO, so the minimum latency is one cycle.
//
// Ports
//   clk, reset                  clock (rising edge), asynchronous active-low reset
//   valid + bundle fields       M/WB bundle: instruction_type, pc, exception,
//                               virtual_addr_exception, aluResult, rob_id
//   flush                       synchronous discard of every buffered entry
//   stall_out                   FIFO full; upstream must hold its bundle
//   rob_wr_valid/rob_wr_ready   handshake toward the ROB result-write port
//   rob_wr_*                    head entry fields (zero when nothing is presented)
//   count                       FIFO occupancy, 0..DEPTH
module wb_rob_writer #(
    parameter int WORD_SIZE       = 32,
    parameter int INSTR_TYPE_SZ   = 2,
    parameter int ROB_ENTRY_WIDTH = 3,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
    input  logic [WORD_SIZE-1:0]       pc,
    input  logic                       exception,
    input  logic [WORD_SIZE-1:0]       virtual_addr_exception,
    input  logic [WORD_SIZE-1:0]       aluResult,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
    input  logic                       flush,
    output logic                       stall_out,
    output logic                       rob_wr_valid,
    input  logic                       rob_wr_ready,
    output logic [INSTR_TYPE_SZ-1:0]   rob_wr_instruction_type,
    output logic [WORD_SIZE-1:0]       rob_wr_pc,
    output logic                       rob_wr_exception,
    output logic [WORD_SIZE-1:0]       rob_wr_virtual_addr_exception,
    output logic [WORD_SIZE-1:0]       rob_wr_aluResult,
    output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_rob_id,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0]   instruction_type;
        logic [WORD_SIZE-1:0]       pc;
        logic                       exception;
        logic [WORD_SIZE-1:0]       virtual_addr_exception;
        logic [WORD_SIZE-1:0]       alu_result;
        logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             in_entry;
    entry_t             out_entry;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               full;
    logic               empty;
    logic               bypass;
    logic               push;
    logic               pop;

    assign in_entry = '{
        instruction_type:       instruction_type,
        pc:                     pc,
        exception:              exception,
        virtual_addr_exception: virtual_addr_exception,
        alu_result:             aluResult,
        rob_id:                 rob_id
    };

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

`ifdef WB_BYPASS_EN
    // Gated with reset so nothing is presented while reset is held.
    assign bypass = reset && empty && valid && rob_wr_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed bundle is delivered directly and never takes a FIFO slot.
    // flush cancels both the push and the pop in the same cycle.
    assign push = valid && !full && !bypass && !flush;
    assign pop  = !empty && rob_wr_ready && !flush;

    // The storage has no reset because its contents are don't-care until
    // count says an entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head presentation: bypass takes priority (it is only possible when the
    // FIFO is empty). Outputs are forced to zero while nothing is presented.
    always_comb begin
        out_entry    = '0;
        rob_wr_valid = 1'b0;
        if (bypass) begin
            out_entry    = in_entry;
            rob_wr_valid = 1'b1;
        end else if (!empty) begin
            out_entry    = mem[rd_ptr_reg];
            rob_wr_valid = 1'b1;
        end
    end

    assign rob_wr_instruction_type       = out_entry.instruction_type;
    assign rob_wr_pc                     = out_entry.pc;
    assign rob_wr_exception              = out_entry.exception;
    assign rob_wr_virtual_addr_exception = out_entry.virtual_addr_exception;
    assign rob_wr_aluResult              = out_entry.alu_result;
    assign rob_wr_rob_id                 = out_entry.rob_id;
    assign stall_out                     = full;
    assign count                         = count_reg;

endmodule

// File: tb/tb_wb_rob_writer.sv
// tb_wb_rob_writer
// Self-checking bench for wb_rob_writer. A negedge monitor keeps a reference
// queue of accepted bundles. It checks count, stall_out and rob_wr_valid on
// every cycle, and it checks the head fields against the queue front.
// Table vectors carry the expected occupancy for the fill, drain and flush
// sequences. Hand-written sequences cover latency, wrap-around and mid-cycle
// reset.
module tb_wb_rob_writer;

    localparam int WS    = 32;
    localparam int TS    = 2;
    localparam int RW    = 3;
    localparam int DEPTH = 4;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [TS-1:0] itype;
        logic [WS-1:0] pc;
        logic          exc;
        logic [WS-1:0] vae;
        logic [WS-1:0] alu;
        logic [RW-1:0] rid;
    } bundle_t;

    typedef struct {
        logic          v;
        logic          rdy;
        logic          fl;
        logic [RW-1:0] rid;
        logic [WS-1:0] pc;
        logic [2:0]    exp_count;
        logic          exp_stall;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid = 1'b0;
    logic          flush = 1'b0;
    logic          rob_wr_ready = 1'b0;
    bundle_t       in_b = '0;
    logic          stall_out;
    logic          rob_wr_valid;
    logic [TS-1:0] rob_wr_instruction_type;
    logic [WS-1:0] rob_wr_pc;
    logic          rob_wr_exception;
    logic [WS-1:0] rob_wr_virtual_addr_exception;
    logic [WS-1:0] rob_wr_aluResult;
    logic [RW-1:0] rob_wr_rob_id;
    logic [2:0]    count;
    bundle_t       out_b;

    int      checks = 0;
    int      failures = 0;
    bit      mon_en = 1'b0;
    bundle_t sb_q[$];
    vec_t    vt[17];

    always #5 clk = ~clk;

    wb_rob_writer #(
        .WORD_SIZE(WS), .INSTR_TYPE_SZ(TS), .ROB_ENTRY_WIDTH(RW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid(valid),
        .instruction_type(in_b.itype),
        .pc(in_b.pc),
        .exception(in_b.exc),
        .virtual_addr_exception(in_b.vae),
        .aluResult(in_b.alu),
        .rob_id(in_b.rid),
        .flush(flush),
        .stall_out(stall_out),
        .rob_wr_valid(rob_wr_valid),
        .rob_wr_ready(rob_wr_ready),
        .rob_wr_instruction_type(rob_wr_instruction_type),
        .rob_wr_pc(rob_wr_pc),
        .rob_wr_exception(rob_wr_exception),
        .rob_wr_virtual_addr_exception(rob_wr_virtual_addr_exception),
        .rob_wr_aluResult(rob_wr_aluResult),
        .rob_wr_rob_id(rob_wr_rob_id),
        .count(count)
    );

    assign out_b = {rob_wr_instruction_type, rob_wr_pc, rob_wr_exception,
                    rob_wr_virtual_addr_exception, rob_wr_aluResult, rob_wr_rob_id};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [RW-1:0] rid, input logic [WS-1:0] pc);
        bundle_t b;
        b.itype = rid[TS-1:0];
        b.pc    = pc;
        b.exc   = 1'b0;
        b.vae   = '0;
        b.alu   = pc * 3;
        b.rid   = rid;
        return b;
    endfunction

    // Called right after a rising edge: drives the inputs for the coming cycle.
    task automatic drive(input logic v, input logic rdy, input logic fl, input bundle_t b);
        valid        = v;
        rob_wr_ready = rdy;
        flush        = fl;
        in_b         = b;
    endtask

    // Scoreboard monitor. It samples on the falling edge, when inputs and outputs
    // are stable, and then advances the reference queue to its post-edge state.
    always @(negedge clk) begin
        int      mc;
        bit      byp_now;
        bundle_t exp_b;
        if (!reset) begin
            sb_q.delete();
        end else if (mon_en) begin
            mc      = sb_q.size();
            byp_now = BYP && (mc == 0) && valid && rob_wr_ready && !flush;
            check("mon_count", count, mc);
            check("mon_stall", stall_out, mc == DEPTH);
            check("mon_valid", rob_wr_valid, (mc != 0) || byp_now);
            if (!rob_wr_valid) begin
                check("mon_idle_zero", out_b, '0);
            end else begin
                exp_b = byp_now ? in_b : ((mc != 0) ? sb_q[0] : bundle_t'('0));
                check("mon_head", out_b, exp_b);
                if (rob_wr_ready && !flush) begin
                    $display("deliver rob_id=%0d pc=%0d exc=%0d vae=%0d", rob_wr_rob_id,
                             rob_wr_pc, rob_wr_exception, rob_wr_virtual_addr_exception);
                end
            end
            if (flush) begin
                sb_q.delete();
            end else begin
                if (rob_wr_ready && mc != 0) begin
                    void'(sb_q.pop_front());
                end
                if (valid && mc < DEPTH && !byp_now) begin
                    sb_q.push_back(in_b);
                end
            end
        end
    end

    initial begin
        // Fill/drain/re-push sequence followed by a flush together with a push.
        vt[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'd100, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 3'd1, 32'd101, 3'd1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 3'd2, 32'd102, 3'd2, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 3'd3, 32'd103, 3'd3, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 3'd4, 32'd104, 3'd4, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd4, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd3, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd2, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd1, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 3'd4, 32'd104, 3'd0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd1, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 3'd5, 32'd200, 3'd0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 3'd6, 32'd201, 3'd1, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 3'd7, 32'd202, 3'd2, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 3'd0, 32'd999, 3'd3, 1'b0};
        vt[15] = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 1'b0, 3'd0, 32'd0,   3'd0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", rob_wr_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_stall", stall_out, 1'b0);
        check("rst_fields", out_b, '0);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single push with ready high: one-cycle latency, or same cycle with bypass.
        drive(1'b1, 1'b1, 1'b0, '{2'd2, 32'd42, 1'b0, 32'd0, 32'd7, 3'd2});
        @(negedge clk); #1;
        check("lat_n_valid", rob_wr_valid, BYP);
        check("lat_n_pc", rob_wr_pc, BYP ? 32'd42 : 32'd0);
        check("lat_n_count", count, 3'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk); #1;
        check("lat_n1_valid", rob_wr_valid, !BYP);
        check("lat_n1_pc", rob_wr_pc, BYP ? 32'd0 : 32'd42);
        check("lat_n1_rid", rob_wr_rob_id, BYP ? 3'd0 : 3'd2);
        check("lat_n1_count", count, BYP ? 3'd0 : 3'd1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("lat_n2_count", count, 3'd0);

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            drive(vt[i].v, vt[i].rdy, vt[i].fl, mk(vt[i].rid, vt[i].pc));
            @(negedge clk); #1;
            check($sformatf("tbl%0d_count", i), count, vt[i].exp_count);
            check($sformatf("tbl%0d_stall", i), stall_out, vt[i].exp_stall);
        end

        // Wrap: hold occupancy at 2 with simultaneous push and pop.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(1'b1, i >= 2, 1'b0, mk(3'(i), 32'(300 + i)));
            @(negedge clk); #1;
            if (i >= 2) check($sformatf("wrap%0d_count", i), count, 3'd2);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 1'b0, '0);
        end

        // Mid-cycle reset with two entries buffered.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 1'b0, mk(3'(i + 5), 32'(500 + i)));
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0);
        check("pre_rst_count", count, 3'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", rob_wr_valid, 1'b0);
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_fields", out_b, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '{2'd1, 32'd600, 1'b1, 32'd12, 32'd9, 3'd3});
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, '0);
        @(negedge clk); #1;
        check("exc_valid", rob_wr_valid, 1'b1);
        check("exc_flag", rob_wr_exception, 1'b1);
        check("exc_vae", rob_wr_virtual_addr_exception, 32'd12);
        check("exc_pc", rob_wr_pc, 32'd600);

        repeat (3) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 1'b0, '0);
        end
        @(negedge clk); #1;
        check("sb_empty", sb_q.size(), 0);
        check("end_count", count, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
